fruit_spawn_scheduler: RTL and testbench
========================================

Name: fruit_spawn_scheduler

Overview:
- Schedules fruit launches into a fixed pool of object slots. Each slot is one objectTransition-style motion instance.
- Every SPAWN_PERIOD movement ticks, it claims a free slot and drives a one-cycle load pulse, plus shared pseudo-random launch position, speed and direction.
- Retires slots when the fruit leaves the screen or is sliced, and keeps hit and miss counters for the score/display logic.
- Sits between the game-state FSM and the per-slot motion engines.

Parameters:
- NUM_SLOTS, 4, number of object slots managed (2..8).
- SPAWN_PERIOD, 60, moveclk rising edges between spawn attempts (>=2).
- SCREEN_H, 480, visible height; launch row is SCREEN_H-1.
- X_MARGIN, 64, left offset added to the random launch column.
- LFSR_SEED, 16'hACE1, LFSR reset value; a zero value is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- moveclk  in  1  slow movement clock, treated as asynchronous data
- enable  in  1  game running; spawning is allowed only while high
- slot_offscreen  in  NUM_SLOTS  per-slot level: fruit has left the screen
- slot_sliced  in  NUM_SLOTS  per-slot level: fruit has been cut by the blade
- slot_active  out  NUM_SLOTS  slot currently owns a live fruit
- slot_load  out  NUM_SLOTS  one-hot, one-cycle pulse: slot latches the launch bus
- init_posx  out  10  launch column, valid while slot_load != 0
- init_posy  out  9  launch row, valid while slot_load != 0
- vx  out  10  horizontal speed magnitude
- vy  out  9  vertical speed magnitude
- dx  out  2  horizontal direction, in motion-engine encoding
- dy  out  2  vertical direction, in motion-engine encoding
- hit_count  out  8  sliced fruits, saturating
- miss_count  out  8  fruits lost off-screen, saturating

Behaviour:
- Reset (async assert, sync deassert via internal 2-flop): all outputs 0, FSM=IDLE, period counter 0, LFSR=LFSR_SEED.
- moveclk handling: 2-flop synchroniser plus rising-edge detect gives `tick`, a 1-clk pulse. Latency from moveclk edge to tick is 3 clk.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk regardless of enable.
- Period counter: increments on tick while enable=1. When it reaches SPAWN_PERIOD-1 on a tick, it wraps to 0 and raises spawn_req. It is held at 0 while enable=0.
- FSM states:
  - IDLE: go to WAIT when enable=1.
  - WAIT: on spawn_req go to PICK. If enable=0, go to IDLE.
  - PICK (1 clk): selects the lowest index i with slot_active[i]=0. If a slot is found, go to LOAD. If all slots are busy, the spawn is dropped silently and the FSM returns to WAIT.
  - LOAD (1 clk): drives the launch bus and returns to WAIT, or to IDLE if enable=0. An in-flight LOAD always completes even if enable drops.
- LOAD outputs (registered from the LFSR value sampled in PICK):
  - slot_load = one-hot(i); slot_active[i] <= 1.
  - init_posx = X_MARGIN + lfsr[8:0], giving 64..575.
  - init_posy = SCREEN_H-1.
  - vx = 1 + lfsr[11:9], giving 1..8.
  - vy = 8 + lfsr[14:12], giving 8..15.
  - dx = {1'b1, lfsr[15]}, i.e. 10 = left, 11 = right.
  - dy = 2'b10, i.e. up.
  - In all other cycles slot_load = 0 and the launch bus holds its last value.
- Retire, evaluated every clk:
  - retire[i] = slot_active[i] & (slot_offscreen[i] | slot_sliced[i]).
  - Retiring clears slot_active[i] next cycle. Retire inputs on inactive slots are ignored.
  - Sliced takes priority over offscreen when both are asserted: counts as a hit only.
- Counters: hit_count += popcount(active & sliced); miss_count += popcount(active & offscreen & ~sliced). Both saturate at 255.
- Simultaneous events:
  - A slot retired in the same cycle as PICK is still seen as busy; it becomes free next cycle.
  - Load and retire can never target the same slot in the same cycle.
- enable=0 does not freeze retirement or the counters. Counters clear only on reset.

Decomposition:
- Shared package fn_pkg holds:
  - the direction encodings DIR_NONE = 2'b00, DIR_NEG = 2'b10, DIR_POS = 2'b11;
  - the FSM state enum;
  - SCREEN_W = 640 and SCREEN_H = 480.
- One natural sub-module: lfsr16 (clk, rst_n, seed, q), reused elsewhere for slicing effects.
- Edge detect, slot pick, FSM and counters stay inline.

Test Plan:
- Reset mid-LOAD: assert rst_n=0 while slot_load != 0. Outputs go to 0 immediately (asynchronous). After release, the first spawn occurs only after SPAWN_PERIOD ticks.
- Basic spawn (SPAWN_PERIOD=4, enable=1, four moveclk edges):
  - exactly one slot_load=4'b0001 pulse, 1 clk wide;
  - slot_active=4'b0001;
  - init_posy=479, dy=2'b10;
  - init_posx in 64..575, vx in 1..8, vy in 8..15, matching the LFSR model.
- Pool full: no retires over 5 periods. Slots 0..3 load in order; the 5th spawn is dropped with slot_load=0, and slot_active stays 4'b1111.
- Retire and reuse: pulse slot_offscreen[1] with slot 1 active. Then slot_active[1]=0 and miss_count=1; the next spawn loads slot 1 (lowest free).
- Simultaneous retire: in one cycle assert slot_sliced=4'b0101 and slot_offscreen=4'b0110 with all slots active. Result is hit_count += 2 and miss_count += 1. Then drive 300 hits and check hit_count saturates at 255.
- Enable drop: deassert enable during PICK. LOAD still completes, the FSM enters IDLE, the period counter stays 0, and no further slot_load pulses occur while enable=0.

Source files
------------

// File: rtl/fn_pkg.sv
// Shared definitions for the fruit game datapath.
// Holds the motion-engine direction encodings, the spawn scheduler FSM
// state type and the screen geometry used by launch and motion logic.
package fn_pkg;

    // Direction encoding understood by the per-slot motion engines.
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_NEG  = 2'b10;   // left / up
    localparam logic [1:0] DIR_POS  = 2'b11;   // right / down

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PICK = 2'd2,
        ST_LOAD = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/fruit_spawn_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11. Free-running: advances every clk.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   seed       : reset value; an all-zero seed is replaced by 16'h0001
//   q          : current register state
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic [15:0] seed_eff;

    // An all-zero state would lock the register up forever.
    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

    always_comb begin
        q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end

    // NOTE: sequential state is always updated with non-blocking (<=)
    // assignments so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= seed_eff;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Fruit spawn scheduler: every SPAWN_PERIOD movement ticks it claims the
// lowest free object slot and pulses that slot's load line for one clk
// while presenting a shared pseudo-random launch bus. Slots are retired
// when their fruit is sliced or leaves the screen; hit/miss counters
// (saturating at 255) feed the score display.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   moveclk             : slow movement clock, synchronised internally
//   enable              : game running; spawning allowed only while high
//   slot_offscreen      : per-slot level, fruit left the screen
//   slot_sliced         : per-slot level, fruit cut by the blade
//   slot_active         : slot owns a live fruit
//   slot_load           : one-hot, one-clk pulse, slot latches launch bus
//   init_posx/init_posy : launch position
//   vx, vy, dx, dy      : launch speed magnitudes and directions
//   hit_count/miss_count: saturating event counters
module fruit_spawn_scheduler #(
    parameter int          NUM_SLOTS    = 4,
    parameter int          SPAWN_PERIOD = 60,
    parameter int          SCREEN_H     = fn_pkg::SCREEN_H,
    parameter int          X_MARGIN     = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 moveclk,
    input  logic                 enable,
    input  logic [NUM_SLOTS-1:0] slot_offscreen,
    input  logic [NUM_SLOTS-1:0] slot_sliced,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_load,
    output logic [9:0]           init_posx,
    output logic [8:0]           init_posy,
    output logic [9:0]           vx,
    output logic [8:0]           vy,
    output logic [1:0]           dx,
    output logic [1:0]           dy,
    output logic [7:0]           hit_count,
    output logic [7:0]           miss_count
);

    import fn_pkg::*;

    localparam int                 CNT_W    = $clog2(SPAWN_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clk edge.
    // ------------------------------------------------------------------
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // moveclk synchroniser and rising-edge detect (3 clk to tick).
    // ------------------------------------------------------------------
    logic mv_meta_q, mv_sync_q, mv_prev_q, tick_q;
    logic tick_d;

    assign tick_d = mv_sync_q & ~mv_prev_q;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            mv_meta_q <= 1'b0;
            mv_sync_q <= 1'b0;
            mv_prev_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            mv_meta_q <= moveclk;
            mv_sync_q <= mv_meta_q;
            mv_prev_q <= mv_sync_q;
            tick_q    <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    logic [15:0] lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_sync_q),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_state_e           state_q, state_d;
    logic [CNT_W-1:0]     period_cnt_q, period_cnt_d;
    logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
    logic [NUM_SLOTS-1:0] slot_load_q, slot_load_d;
    logic [9:0]           init_posx_q, init_posx_d;
    logic [8:0]           init_posy_q, init_posy_d;
    logic [9:0]           vx_q, vx_d;
    logic [8:0]           vy_q, vy_d;
    logic [1:0]           dx_q, dx_d;
    logic [1:0]           dy_q, dy_d;
    logic [7:0]           hit_q, hit_d;
    logic [7:0]           miss_q, miss_d;

    logic                 spawn_req;
    logic [NUM_SLOTS-1:0] retire;
    logic [NUM_SLOTS-1:0] pick_onehot;
    logic                 pick_found;
    logic [3:0]           hit_inc, miss_inc;
    logic [8:0]           hit_sum, miss_sum;

    // Period counter: only runs while the game is enabled.
    assign spawn_req = enable & tick_q & (period_cnt_q == CNT_LAST);

    always_comb begin
        period_cnt_d = period_cnt_q;
        if (!enable) begin
            period_cnt_d = '0;
        end else if (tick_q) begin
            period_cnt_d = (period_cnt_q == CNT_LAST) ? '0
                                                      : period_cnt_q + CNT_W'(1);
        end
    end

    // Lowest-index free slot. A slot retiring this cycle still reads busy.
    // NOTE: every variable written in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_onehot = '0;
        pick_found  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active_q[i] && !pick_found) begin
                pick_onehot[i] = 1'b1;
                pick_found     = 1'b1;
            end
        end
    end

    // Retirement and counters run independently of enable.
    assign retire = slot_active_q & (slot_offscreen | slot_sliced);

    always_comb begin
        hit_inc  = 4'd0;
        miss_inc = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_inc  = hit_inc  + {3'd0, slot_active_q[i] & slot_sliced[i]};
            // Sliced wins when both flags are up: such a slot is a hit only.
            miss_inc = miss_inc + {3'd0, slot_active_q[i] & slot_offscreen[i]
                                         & ~slot_sliced[i]};
        end
        hit_sum  = {1'b0, hit_q}  + {5'd0, hit_inc};
        miss_sum = {1'b0, miss_q} + {5'd0, miss_inc};
        hit_d    = hit_sum[8]  ? 8'hFF : hit_sum[7:0];
        miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    // FSM next state and launch bus. The bus is captured from the LFSR value
    // of the PICK cycle and then held until the next launch.
    always_comb begin
        state_d       = state_q;
        slot_load_d   = '0;
        slot_active_d = slot_active_q & ~retire;
        init_posx_d   = init_posx_q;
        init_posy_d   = init_posy_q;
        vx_d          = vx_q;
        vy_d          = vy_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable)        state_d = ST_IDLE;
                else if (spawn_req) state_d = ST_PICK;
            end
            ST_PICK: begin
                if (pick_found) begin
                    state_d       = ST_LOAD;
                    slot_load_d   = pick_onehot;
                    slot_active_d = slot_active_d | pick_onehot;
                    init_posx_d   = 10'(X_MARGIN) + {1'b0, lfsr[8:0]};
                    init_posy_d   = 9'(SCREEN_H - 1);
                    vx_d          = 10'd1 + {7'd0, lfsr[11:9]};
                    vy_d          = 9'd8 + {6'd0, lfsr[14:12]};
                    dx_d          = lfsr[15] ? DIR_POS : DIR_NEG;
                    dy_d          = DIR_NEG;
                end else begin
                    state_d = ST_WAIT;   // pool full: spawn dropped
                end
            end
            ST_LOAD: begin
                state_d = enable ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q       <= ST_IDLE;
            period_cnt_q  <= '0;
            slot_active_q <= '0;
            slot_load_q   <= '0;
            init_posx_q   <= '0;
            init_posy_q   <= '0;
            vx_q          <= '0;
            vy_q          <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            slot_active_q <= slot_active_d;
            slot_load_q   <= slot_load_d;
            init_posx_q   <= init_posx_d;
            init_posy_q   <= init_posy_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
        end
    end

    assign slot_active = slot_active_q;
    assign slot_load   = slot_load_q;
    assign init_posx   = init_posx_q;
    assign init_posy   = init_posy_q;
    assign vx          = vx_q;
    assign vy          = vy_q;
    assign dx          = dx_q;
    assign dy          = dy_q;
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;

endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Directed self-checking bench for fruit_spawn_scheduler (4 slots, period 4).
module tb_fruit_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       moveclk;
    logic       enable;
    logic [3:0] slot_offscreen;
    logic [3:0] slot_sliced;
    logic [3:0] slot_active;
    logic [3:0] slot_load;
    logic [9:0] init_posx;
    logic [8:0] init_posy;
    logic [9:0] vx;
    logic [8:0] vy;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fruit_spawn_scheduler #(
        .NUM_SLOTS    (4),
        .SPAWN_PERIOD (4),
        .SCREEN_H     (480),
        .X_MARGIN     (64),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .moveclk        (moveclk),
        .enable         (enable),
        .slot_offscreen (slot_offscreen),
        .slot_sliced    (slot_sliced),
        .slot_active    (slot_active),
        .slot_load      (slot_load),
        .init_posx      (init_posx),
        .init_posy      (init_posy),
        .vx             (vx),
        .vy             (vy),
        .dx             (dx),
        .dy             (dy),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    // Reference LFSR: released two clk after rst_n rises, then steps each clk.
    logic        m_rs1, m_rs2;
    logic [15:0] m_lfsr, m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rs1  <= 1'b0;
            m_rs2  <= 1'b0;
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_rs1  <= 1'b1;
            m_rs2  <= m_rs1;
            m_prev <= m_lfsr;
            if (m_rs2)
                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Load monitor: records each launch and the LFSR value of its PICK cycle.
    int          load_cnt  = 0;
    int          width_err = 0;
    logic        prev_load = 1'b0;
    logic [3:0]  last_load = '0;
    logic [9:0]  cap_posx, cap_vx;
    logic [8:0]  cap_posy, cap_vy;
    logic [1:0]  cap_dx, cap_dy;
    logic [15:0] cap_exp;

    always @(negedge clk) begin
        if (slot_load !== 4'b0000) begin
            if (prev_load) width_err++;
            load_cnt++;
            last_load = slot_load;
            cap_posx  = init_posx;
            cap_posy  = init_posy;
            cap_vx    = vx;
            cap_vy    = vy;
            cap_dx    = dx;
            cap_dy    = dy;
            cap_exp   = m_prev;
        end
        prev_load = (slot_load !== 4'b0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_launch(input string tag);
        int ex_posx, ex_vx, ex_vy, ex_dx;
        ex_posx = 64 + int'(cap_exp[8:0]);
        ex_vx   = 1 + int'(cap_exp[11:9]);
        ex_vy   = 8 + int'(cap_exp[14:12]);
        ex_dx   = cap_exp[15] ? 3 : 2;
        check({tag, "_posx"}, 32'(cap_posx), 32'(ex_posx));
        check({tag, "_posx_range"}, 32'(cap_posx >= 10'd64 && cap_posx <= 10'd575), 32'd1);
        check({tag, "_posy"}, 32'(cap_posy), 32'd479);
        check({tag, "_vx"}, 32'(cap_vx), 32'(ex_vx));
        check({tag, "_vy"}, 32'(cap_vy), 32'(ex_vy));
        check({tag, "_dx"}, 32'(cap_dx), 32'(ex_dx));
        check({tag, "_dy"}, 32'(cap_dy), 32'd2);
    endtask

    // One moveclk period: 4 clk high, 4 clk low. A spawn lands 5 clk after rise.
    task automatic mv_tick();
        @(negedge clk) moveclk = 1'b1;
        repeat (4) @(negedge clk);
        moveclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) mv_tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic seen;

        rst_n          = 1'b1;
        moveclk        = 1'b0;
        enable         = 1'b0;
        slot_offscreen = '0;
        slot_sliced    = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_active", 32'(slot_active), 32'd0);
        check("rst_load",   32'(slot_load),   32'd0);
        check("rst_posx",   32'(init_posx),   32'd0);
        check("rst_hit",    32'(hit_count),   32'd0);
        check("rst_miss",   32'(miss_count),  32'd0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Basic spawn: four ticks produce one load of slot 0
        ticks(3);
        check("basic_no_early_load", 32'(load_cnt), 32'd0);
        ticks(1);
        check("basic_load_cnt", 32'(load_cnt), 32'd1);
        check("basic_load_slot", 32'(last_load), 32'b0001);
        check("basic_active", 32'(slot_active), 32'b0001);
        check_launch("basic");

        // Pool full: slots 1..3 fill in order, the fifth spawn is dropped
        for (int p = 0; p < 3; p++) begin
            ticks(4);
            check("pool_load_cnt", 32'(load_cnt), 32'(p + 2));
            check("pool_load_slot", 32'(last_load), 32'(1 << (p + 1)));
            check_launch("pool");
        end
        ticks(4);
        check("pool_drop_cnt", 32'(load_cnt), 32'd4);
        check("pool_full_active", 32'(slot_active), 32'b1111);

        // Retire and reuse
        @(negedge clk) slot_offscreen = 4'b0010;
        @(negedge clk) slot_offscreen = 4'b0000;
        @(negedge clk);
        check("retire_active", 32'(slot_active), 32'b1101);
        check("retire_miss", 32'(miss_count), 32'd1);
        check("retire_hit", 32'(hit_count), 32'd0);
        ticks(4);
        check("reuse_load_slot", 32'(last_load), 32'b0010);
        check("reuse_active", 32'(slot_active), 32'b1111);

        // Simultaneous retire: slots 0,2 sliced; 1 offscreen; 2 also offscreen
        @(negedge clk) begin
            slot_sliced    = 4'b0101;
            slot_offscreen = 4'b0110;
        end
        @(negedge clk) begin
            slot_sliced    = 4'b0000;
            slot_offscreen = 4'b0000;
        end
        check("simul_hit", 32'(hit_count), 32'd2);
        check("simul_miss", 32'(miss_count), 32'd2);
        check("simul_active", 32'(slot_active), 32'b1000);

        // Retire flag on an inactive slot is ignored
        @(negedge clk) slot_offscreen = 4'b0001;
        @(negedge clk) slot_offscreen = 4'b0000;
        check("inactive_ignored", 32'(miss_count), 32'd2);

        // Hit saturation: every spawned fruit is sliced straight away
        @(negedge clk) slot_sliced = 4'b1111;
        base = load_cnt;
        ticks(400);
        check("sat_mid_loads", 32'(load_cnt - base), 32'd100);
        check("sat_mid_hit", 32'(hit_count), 32'd103);
        ticks(800);
        check("sat_hit", 32'(hit_count), 32'd255);
        check("sat_miss", 32'(miss_count), 32'd2);
        @(negedge clk) slot_sliced = 4'b0000;
        @(negedge clk);
        check("sat_active", 32'(slot_active), 32'b0000);

        // Enable drop during PICK: LOAD completes, FSM idles, counter cleared
        ticks(3);
        base = load_cnt;
        @(negedge clk) moveclk = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        moveclk = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_load_done", 32'(load_cnt - base), 32'd1);
        check("drop_load_slot", 32'(last_load), 32'b0001);
        check("drop_fsm_idle", 32'(dut.state_q), 32'(fn_pkg::ST_IDLE));
        ticks(8);
        check("drop_no_loads", 32'(load_cnt - base), 32'd1);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        ticks(3);
        check("drop_cnt_cleared", 32'(load_cnt - base), 32'd1);
        ticks(1);
        check("drop_resume_slot", 32'(last_load), 32'b0010);

        // Reset while a LOAD pulse is on the bus
        ticks(3);
        base = load_cnt;
        @(negedge clk) moveclk = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (slot_load !== 4'b0000) seen = 1'b1;
        end
        check("midload_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midload_load", 32'(slot_load), 32'd0);
        check("midload_active", 32'(slot_active), 32'd0);
        check("midload_hit", 32'(hit_count), 32'd0);
        check("midload_posy", 32'(init_posy), 32'd0);
        @(negedge clk) moveclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        base = load_cnt;
        ticks(3);
        check("post_rst_no_early", 32'(load_cnt - base), 32'd0);
        ticks(1);
        check("post_rst_load", 32'(load_cnt - base), 32'd1);
        check("post_rst_slot", 32'(last_load), 32'b0001);
        check("post_rst_active", 32'(slot_active), 32'b0001);
        check_launch("post_rst");

        check("load_width", 32'(width_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
